// File: rtl/ethernet_sys_timer_sched_if.sv
// rtl/ethernet_sys_timer_sched_if.sv - arm/cancel/expiry handshake bundle (ETHSYS_TSCHED_AUTORELOAD_EN adds periodic signals)
interface ethernet_sys_timer_sched_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              arm_valid;
    logic              arm_ready;
    logic [CH_W-1:0]   arm_ch;
    logic [CNT_W-1:0]  arm_timeout;
    logic              cancel_valid;
    logic [CH_W-1:0]   cancel_ch;
    logic              expire_valid;
    logic              expire_ready;
    logic [CH_W-1:0]   expire_ch;
    logic [NUM_CH-1:0] busy;
`ifdef ETHSYS_TSCHED_AUTORELOAD_EN
    logic              arm_periodic;
    logic [NUM_CH-1:0] overrun;
`endif

    modport master (
`ifdef ETHSYS_TSCHED_AUTORELOAD_EN
        output arm_periodic,
        input  overrun,
`endif
        output arm_valid, arm_ch, arm_timeout, cancel_valid, cancel_ch, expire_ready,
        input  arm_ready, expire_valid, expire_ch, busy
    );

    modport slave (
`ifdef ETHSYS_TSCHED_AUTORELOAD_EN
        input  arm_periodic,
        output overrun,
`endif
        input  arm_valid, arm_ch, arm_timeout, cancel_valid, cancel_ch, expire_ready,
        output arm_ready, expire_valid, expire_ch, busy
    );
endinterface

// File: rtl/ethernet_sys_timer_sched.sv
// rtl/ethernet_sys_timer_sched.sv - shared-prescaler multi-channel timeout scheduler (option: ETHSYS_TSCHED_AUTORELOAD_EN)
module ethernet_sys_timer_sched #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int PRESCALE = 50000
) (
    input  logic                      clk,
    input  logic                      reset,
    ethernet_sys_timer_sched_if.slave bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t            state;
    logic [CH_W-1:0]   idx;
    logic [PS_W-1:0]   ps_cnt;
    logic              tick;
    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] pending;
    logic [CH_W-1:0]   rr_ptr;
    logic              expire_valid_q;
    logic [CH_W-1:0]   expire_ch_q;
    logic              arm_fire;
    logic              load_en;
    logic              grant_found;
    logic [CH_W-1:0]   grant_ch;
    logic [CH_W-1:0]   cand;
`ifdef ETHSYS_TSCHED_AUTORELOAD_EN
    logic [CNT_W-1:0]  period [NUM_CH];
    logic [NUM_CH-1:0] periodic;
    logic [NUM_CH-1:0] overrun_q;
    assign bus.overrun = overrun_q;
`endif

    assign tick             = (ps_cnt == PS_W'(PRESCALE - 1));
    assign bus.arm_ready    = (state == IDLE);
    assign arm_fire         = bus.arm_valid && (state == IDLE);
    assign load_en          = !expire_valid_q || bus.expire_ready;
    assign bus.busy         = active;
    assign bus.expire_valid = expire_valid_q;
    assign bus.expire_ch    = expire_ch_q;

    // Free-running tick prescaler, wraps at PRESCALE-1
    always_ff @(posedge clk) begin
        if (reset || tick) ps_cnt <= '0;
        else               ps_cnt <= ps_cnt + 1'b1;
    end

    // Scan sequencer: one channel per cycle after each tick, then back to idle
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: if (tick) begin
                    state <= SCAN;
                    idx   <= '0;
                end
                SCAN: begin
                    if (idx == LAST_CH) state <= IDLE;
                    else                idx   <= idx + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Round-robin pick of the next pending channel, starting after the last grant
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        cand        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = CH_W'((int'(rr_ptr) + 1 + i) % NUM_CH);
            if (!grant_found && pending[cand]) begin
                grant_found = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    // Expiry output register: holds an event until accepted, then reloads
    always_ff @(posedge clk) begin
        if (reset) begin
            expire_valid_q <= 1'b0;
            expire_ch_q    <= '0;
            rr_ptr         <= LAST_CH;
        end else if (load_en) begin
            expire_valid_q <= grant_found;
            if (grant_found) begin
                expire_ch_q <= grant_ch;
                rr_ptr      <= grant_ch;
            end
        end
    end

    // Per-channel count/active/pending; later assignments win (cancel > arm > scan > grant)
    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= '0;
            pending <= '0;
            for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
`ifdef ETHSYS_TSCHED_AUTORELOAD_EN
            periodic  <= '0;
            overrun_q <= '0;
            for (int c = 0; c < NUM_CH; c++) period[c] <= '0;
`endif
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (load_en && grant_found && (grant_ch == CH_W'(c))) pending[c] <= 1'b0;
                if ((state == SCAN) && (idx == CH_W'(c)) && active[c]) begin
                    if (cnt[c] == CNT_W'(1)) begin
`ifdef ETHSYS_TSCHED_AUTORELOAD_EN
                        if (periodic[c]) cnt[c]    <= period[c];
                        else             active[c] <= 1'b0;
                        // A pending bit being granted this cycle has left the queue, so re-queue
                        if (pending[c] && !(load_en && grant_found && (grant_ch == CH_W'(c))))
                            overrun_q[c] <= 1'b1;
                        else
                            pending[c] <= 1'b1;
`else
                        active[c]  <= 1'b0;
                        pending[c] <= 1'b1;
`endif
                    end else begin
                        cnt[c] <= cnt[c] - 1'b1;
                    end
                end
                if (arm_fire && (bus.arm_ch == CH_W'(c))) begin
                    cnt[c]     <= bus.arm_timeout;
                    active[c]  <= (bus.arm_timeout != '0);
                    pending[c] <= (bus.arm_timeout == '0);
`ifdef ETHSYS_TSCHED_AUTORELOAD_EN
                    periodic[c]  <= bus.arm_periodic;
                    period[c]    <= bus.arm_timeout;
                    overrun_q[c] <= 1'b0;
`endif
                end
                if (bus.cancel_valid && (bus.cancel_ch == CH_W'(c))) begin
                    active[c]  <= 1'b0;
                    pending[c] <= 1'b0;
`ifdef ETHSYS_TSCHED_AUTORELOAD_EN
                    overrun_q[c] <= 1'b0;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_ethernet_sys_timer_sched.sv
// tb/tb_ethernet_sys_timer_sched.sv - self-checking bench for ethernet_sys_timer_sched
module tb_ethernet_sys_timer_sched;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int PS     = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc;
    int   checks = 0;
    int   failures = 0;

    ethernet_sys_timer_sched_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    ethernet_sys_timer_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE(PS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Cycle index since the last reset edge; the prescaler phase is cyc % PS
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference timing: a channel armed at cycle a with T ticks is due on the T-th tick at or
    // after a; the event appears 3+ch cycles after that tick (scan offset, pending, output reg).
    function automatic int exp_cycle(input int a, input int ch, input int t);
        int tf;
        if (t == 0) return a + 2;
        tf = a + (PS - 1 - (a % PS));
        return tf + PS * (t - 1) + 3 + ch;
    endfunction

    task automatic do_arm(input int ch, input int t, output int acc);
        bus.arm_valid   = 1'b1;
        bus.arm_ch      = 2'(ch);
        bus.arm_timeout = 16'(t);
        acc = -1;
        for (int i = 0; i < 40 && acc < 0; i++) begin
            if (bus.arm_ready) acc = cyc;
            else @(negedge clk);
        end
        @(negedge clk);
        bus.arm_valid = 1'b0;
        if (acc < 0) chk("arm_accept_timeout", 0, 1);
    endtask

    task automatic wait_event(input int bound, output int ecyc, output int ech);
        ecyc = -1;
        ech  = -1;
        for (int i = 0; i < bound && ecyc < 0; i++) begin
            @(negedge clk);
            if (bus.expire_valid) begin
                ecyc = cyc;
                ech  = int'(bus.expire_ch);
            end
        end
    endtask

    task automatic count_events(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.expire_valid) cnt++;
        end
    endtask

    task automatic sync_phase(input int p);
        bit hit = 1'b0;
        for (int i = 0; i < 3 * PS && !hit; i++) begin
            @(negedge clk);
            if ((cyc % PS) == p && cyc >= PS) hit = 1'b1;
        end
        if (!hit) chk("sync_timeout", 0, 1);
    endtask

    initial begin
        int a, a1, a2, e, ech, n, ch, t, tf;
        int q[$];
        bus.arm_valid    = 1'b0;
        bus.arm_ch       = '0;
        bus.arm_timeout  = '0;
        bus.cancel_valid = 1'b0;
        bus.cancel_ch    = '0;
        bus.expire_ready = 1'b1;
`ifdef ETHSYS_TSCHED_AUTORELOAD_EN
        bus.arm_periodic = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_expire_valid", 32'(bus.expire_valid), 0);
        chk("rst_expire_ch", 32'(bus.expire_ch), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_arm_ready", 32'(bus.arm_ready), 1);

        // Single one-shot expiry
        do_arm(2, 3, a);
        chk("t1_busy2_set", 32'(bus.busy[2]), 1);
        wait_event(80, e, ech);
        chk("t1_cycle", e, exp_cycle(a, 2, 3));
        chk("t1_ch", ech, 2);
        chk("t1_busy2_clr", 32'(bus.busy[2]), 0);
        count_events(10 * PS, n);
        chk("t1_no_more", n, 0);

        // Back-pressure and round-robin order
        bus.expire_ready = 1'b0;
        sync_phase(4);
        do_arm(0, 1, a);
        do_arm(1, 1, a1);
        do_arm(3, 1, a2);
        wait_event(40, e, ech);
        chk("t2_first_cycle", e, exp_cycle(a, 0, 1));
        chk("t2_first_ch", ech, 0);
        repeat (10) @(negedge clk);
        chk("t2_hold_valid", 32'(bus.expire_valid), 1);
        chk("t2_hold_ch", 32'(bus.expire_ch), 0);
        bus.expire_ready = 1'b1;
        @(negedge clk);
        chk("t2_next_ch1", 32'(bus.expire_ch), 1);
        chk("t2_next_valid1", 32'(bus.expire_valid), 1);
        @(negedge clk);
        chk("t2_next_ch3", 32'(bus.expire_ch), 3);
        chk("t2_next_valid3", 32'(bus.expire_valid), 1);
        @(negedge clk);
        chk("t2_drained", 32'(bus.expire_valid), 0);

        // Cancel after two ticks
        do_arm(1, 5, a);
        tf = a + (PS - 1 - (a % PS));
        for (int i = 0; i < 60 && cyc < tf + PS + 5; i++) @(negedge clk);
        chk("t3_busy_before", 32'(bus.busy[1]), 1);
        bus.cancel_valid = 1'b1;
        bus.cancel_ch    = 2'd1;
        @(negedge clk);
        bus.cancel_valid = 1'b0;
        chk("t3_busy_after", 32'(bus.busy[1]), 0);
        count_events(10 * PS, n);
        chk("t3_no_event", n, 0);

        // Zero timeout: immediate event without a tick
        sync_phase(4);
        do_arm(3, 0, a);
        chk("t4_busy3", 32'(bus.busy[3]), 0);
        wait_event(10, e, ech);
        chk("t4_cycle", e, a + 2);
        chk("t4_ch", ech, 3);

        // Arm and cancel together: cancel wins
        sync_phase(4);
        bus.arm_valid    = 1'b1;
        bus.arm_ch       = 2'd0;
        bus.arm_timeout  = 16'd1;
        bus.cancel_valid = 1'b1;
        bus.cancel_ch    = 2'd0;
        @(negedge clk);
        bus.arm_valid    = 1'b0;
        bus.cancel_valid = 1'b0;
        chk("t5_busy0", 32'(bus.busy[0]), 0);
        count_events(5 * PS, n);
        chk("t5_no_event", n, 0);

        // Arm during scan is held off until idle
        sync_phase(0);
        chk("t6_ready_in_scan", 32'(bus.arm_ready), 0);
        do_arm(2, 1, a);
        chk("t6_accept_phase", a % PS, 4);
        wait_event(40, e, ech);
        chk("t6_cycle", e, exp_cycle(a, 2, 1));
        chk("t6_ch", ech, 2);

        // Randomized single-channel arms against the timing model
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 9)) @(negedge clk);
            ch = int'($urandom_range(0, NUM_CH - 1));
            t  = int'($urandom_range(0, 4));
            do_arm(ch, t, a);
            wait_event(8 * PS, e, ech);
            chk("rnd_cycle", e, exp_cycle(a, ch, t));
            chk("rnd_ch", ech, ch);
            chk("rnd_busy_clr", 32'(bus.busy[ch]), 0);
        end

        // Reset mid-operation discards armed channels
        do_arm(1, 1, a);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_busy", 32'(bus.busy), 0);
        chk("rst_mid_ready", 32'(bus.arm_ready), 1);
        count_events(4 * PS, n);
        chk("rst_mid_no_event", n, 0);

`ifdef ETHSYS_TSCHED_AUTORELOAD_EN
        // Periodic channel with back-pressure: overrun, single held event, then steady cadence
        bus.expire_ready = 1'b0;
        bus.arm_periodic = 1'b1;
        do_arm(0, 2, a);
        bus.arm_periodic = 1'b0;
        tf = a + (PS - 1 - (a % PS));
        repeat (7 * PS) @(negedge clk);
        chk("p_overrun", 32'(bus.overrun[0]), 1);
        chk("p_held_valid", 32'(bus.expire_valid), 1);
        chk("p_held_ch", 32'(bus.expire_ch), 0);
        chk("p_busy", 32'(bus.busy[0]), 1);
        bus.expire_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.expire_valid) q.push_back(cyc);
        end
        chk("p_enough_events", 32'(q.size() >= 3), 1);
        if (q.size() >= 2) begin
            chk("p_interval", q[q.size() - 1] - q[q.size() - 2], 2 * PS);
            chk("p_phase", (q[q.size() - 1] - (tf + PS + 3)) % (2 * PS), 0);
        end
        bus.cancel_valid = 1'b1;
        bus.cancel_ch    = 2'd0;
        @(negedge clk);
        bus.cancel_valid = 1'b0;
        chk("p_cancel_overrun", 32'(bus.overrun[0]), 0);
        chk("p_cancel_busy", 32'(bus.busy[0]), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
